// File: rtl/infer_seq_fix12.sv
// infer_seq_fix12: sequences one engine inference per request and reports the argmax class.
// Ports: clk; rst (async, active-low); req_valid/req_ready request handshake;
//   eng_reset/eng_start one-cycle engine pulses, eng_done engine finished level;
//   eng_out_idx/eng_out engine output mux select and same-cycle signed score;
//   res_valid/res_ready result handshake with res_digit, res_score, res_timeout; busy when not IDLE.
// Optional: define INFER_SEQ_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYCLES cycles.
module infer_seq_fix12 #(
  parameter int DATA_WIDTH     = 12,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  output logic                         eng_reset,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic [3:0]                   eng_out_idx,
  input  logic signed [DATA_WIDTH-1:0] eng_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3:0]                   res_digit,
  output logic signed [DATA_WIDTH-1:0] res_score,
  output logic                         res_timeout,
  output logic                         busy
);
  typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, SCAN, RESP} state_t;
  localparam logic [3:0] LAST = 4'(NUM_CLASSES - 1);
  state_t state, state_nx;
  logic [3:0] idx, best_idx, cand_idx;
  logic signed [DATA_WIDTH-1:0] best_score, cand_score;
  logic take, last, tmo;
  // idx 0 always loads; later entries replace only on a strictly greater score, so ties keep the lowest index
  always_comb begin
    take       = (idx == 4'd0) || (eng_out > best_score);
    cand_score = take ? eng_out : best_score;
    cand_idx   = take ? idx : best_idx;
    last       = idx == LAST;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? CLEAR : IDLE;
      CLEAR:   state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    state_nx = eng_done ? SCAN : (tmo ? RESP : WAIT);
      SCAN:    state_nx = last ? RESP : SCAN;
      RESP:    state_nx = res_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  assign req_ready   = state == IDLE;
  assign eng_reset   = state == CLEAR;
  assign eng_start   = state == START;
  assign eng_out_idx = (state == SCAN) ? idx : 4'd0;
  assign res_valid   = state == RESP;
  assign busy        = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      best_idx   <= '0;
      best_score <= '0;
      res_digit  <= '0;
      res_score  <= '0;
    end else begin
      state <= state_nx;
      idx   <= (state == SCAN && !last) ? idx + 4'd1 : 4'd0;
      if (state == SCAN) begin
        best_idx   <= cand_idx;
        best_score <= cand_score;
      end
      if (state == SCAN && last) begin
        res_digit <= cand_idx;
        res_score <= cand_score;
      end else if (state == WAIT && !eng_done && tmo) begin
        res_digit <= 4'hF;
        res_score <= '0;
      end
    end
  end
`ifdef INFER_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt        <= '0;
      res_timeout <= 1'b0;
    end else begin
      tcnt <= (state == WAIT) ? tcnt + TW'(1) : '0;
      if (state == SCAN && last) res_timeout <= 1'b0;
      else if (state == WAIT && !eng_done && tmo) res_timeout <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign res_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_infer_seq_fix12.sv
// tb_infer_seq_fix12: scoreboard bench for infer_seq_fix12 with a behavioural engine model.
module tb_infer_seq_fix12;
  localparam int W = 12;
  localparam int N = 10;
  typedef struct {logic [3:0] d; logic signed [W-1:0] s;} exp_t;
  logic clk = 0, rst = 0, req_valid = 0, eng_done = 0, res_ready = 0;
  logic req_ready, eng_reset, eng_start, res_valid, res_timeout, busy;
  logic [3:0] eng_out_idx, res_digit;
  logic signed [W-1:0] eng_out, res_score;
  logic signed [W-1:0] sc [N];
  exp_t sb[$];
  exp_t e;
  int pass = 0, total = 0, cyc = 0, done_dly = 20, ecnt = 0, done_at = 0, n_rst = 0, n_start = 0;

  infer_seq_fix12 #(.DATA_WIDTH(W), .NUM_CLASSES(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
    .eng_out_idx(eng_out_idx), .eng_out(eng_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_digit(res_digit), .res_score(res_score),
    .res_timeout(res_timeout), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always_comb eng_out = (eng_out_idx < 4'(N)) ? sc[eng_out_idx] : '0;

  // engine: raises eng_done for one cycle done_dly cycles after eng_start (never if done_dly < 0)
  always @(negedge clk) begin
    eng_done = 0;
    if (eng_reset) n_rst++;
    if (eng_start) begin
      n_start++;
      ecnt = done_dly;
    end else if (ecnt > 0) begin
      ecnt--;
      if (ecnt == 0) begin
        eng_done = 1;
        done_at = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  function automatic exp_t model();
    int b = 0;
    for (int i = 1; i < N; i++) if (sc[i] > sc[b]) b = i;
    return '{4'(b), sc[b]};
  endfunction

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if ({busy, res_valid, eng_reset, eng_start, res_timeout} !== 5'b0) $display("FAIL rst_ctrl got %b exp 00000", {busy, res_valid, eng_reset, eng_start, res_timeout}); else pass++;
    total++; if ({eng_out_idx, res_digit, res_score} !== '0) $display("FAIL rst_data got %h/%h/%h exp 0", eng_out_idx, res_digit, res_score); else pass++;
    rst = 1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else pass++;
  endtask

  task automatic test_nominal();
    int n;
    sc = '{-5, 3, 120, 7, 0, -2048, 119, 1, 2, 4};
    done_dly = 20;
    sb.push_back(model());
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    total++; if ({eng_reset, eng_start, busy, req_ready} !== 4'b1010) $display("FAIL nom_clear got %b exp 1010", {eng_reset, eng_start, busy, req_ready}); else pass++;
    @(negedge clk);
    total++; if ({eng_reset, eng_start} !== 2'b01) $display("FAIL nom_start got %b exp 01", {eng_reset, eng_start}); else pass++;
    wait_res(n);
    total++; if (res_valid !== 1'b1) $display("FAIL nom_valid got %b exp 1", res_valid); else pass++;
    total++; if (cyc - done_at !== 11) $display("FAIL nom_latency got %0d exp 11", cyc - done_at); else pass++;
    e = sb.pop_front();
    total++; if (res_digit !== e.d || res_digit !== 4'd2) $display("FAIL nom_digit got %0d exp 2", res_digit); else pass++;
    total++; if (res_score !== e.s || res_score !== 12'sd120) $display("FAIL nom_score got %0d exp 120", res_score); else pass++;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    total++; if ({res_valid, req_ready, res_digit} !== {2'b01, 4'd2}) $display("FAIL nom_after got %b exp 010010", {res_valid, req_ready, res_digit}); else pass++;
  endtask

  task automatic test_tie();
    int n;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) sc[i] = (k == 0) ? ((i == 4 || i == 7) ? 12'sd500 : -12'sd100) : -12'sd2048;
      done_dly = 3;
      sb.push_back(model());
      req_valid = 1;
      @(negedge clk);
      req_valid = 0;
      wait_res(n);
      e = sb.pop_front();
      total++; if (res_valid !== 1'b1 || res_digit !== e.d || res_digit !== ((k == 0) ? 4'd4 : 4'd0)) $display("FAIL tie%0d_digit got %0d exp %0d", k, res_digit, e.d); else pass++;
      total++; if (res_score !== e.s) $display("FAIL tie%0d_score got %0d exp %0d", k, res_score, e.s); else pass++;
      res_ready = 1;
      @(negedge clk);
      res_ready = 0;
    end
  endtask

  task automatic test_backpressure();
    int n;
    for (int i = 0; i < N; i++) sc[i] = W'($urandom_range(0, 4095));
    done_dly = 4;
    sb.push_back(model());
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    wait_res(n);
    e = sb.pop_front();
    total++; if (res_valid !== 1'b1 || res_digit !== e.d || res_score !== e.s) $display("FAIL bp_result got %0d/%0d exp %0d/%0d", res_digit, res_score, e.d, e.s); else pass++;
    for (int i = 0; i < 8; i++) begin
      req_valid = i[0];
      @(negedge clk);
      total++; if ({res_valid, req_ready} !== 2'b10 || res_digit !== e.d || res_score !== e.s) $display("FAIL bp_hold%0d got %b %0d/%0d exp 10 %0d/%0d", i, {res_valid, req_ready}, res_digit, res_score, e.d, e.s); else pass++;
    end
    req_valid = 0;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    total++; if (req_ready !== 1'b1) $display("FAIL bp_release got %b exp 1", req_ready); else pass++;
    @(negedge clk);
    total++; if ({busy, eng_reset} !== 2'b00) $display("FAIL bp_not_queued got %b exp 00", {busy, eng_reset}); else pass++;
  endtask

  task automatic test_midreset();
    int n;
    sc = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
    done_dly = 5;
    sb.push_back(model());
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (eng_out_idx !== 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++; if (eng_out_idx !== 4'd5) $display("FAIL mr_reach got %0d exp 5", eng_out_idx); else pass++;
    rst = 0;
    #1;
    total++; if ({busy, res_valid, eng_reset, eng_start, res_timeout, eng_out_idx, res_digit} !== '0 || res_score !== '0) $display("FAIL mr_outputs got %b %0d exp 0", {busy, res_valid, eng_reset, eng_start, res_timeout, eng_out_idx, res_digit}, res_score); else pass++;
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    sc = '{-1, -2, -3, 7, -5, -6, -7, -8, -9, 6};
    sb.push_back(model());
    n_rst = 0;
    n_start = 0;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    total++; if (eng_reset !== 1'b1) $display("FAIL mr_clear got %b exp 1", eng_reset); else pass++;
    @(negedge clk);
    total++; if (eng_start !== 1'b1) $display("FAIL mr_start got %b exp 1", eng_start); else pass++;
    wait_res(n);
    e = sb.pop_front();
    total++; if (res_valid !== 1'b1 || res_digit !== e.d || res_score !== e.s) $display("FAIL mr_result got %0d/%0d exp %0d/%0d", res_digit, res_score, e.d, e.s); else pass++;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic test_timeout();
    int n;
    done_dly = -1;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
`ifdef INFER_SEQ_TIMEOUT_EN
    sb.push_back('{4'hF, '0});
    wait_res(n);
    e = sb.pop_front();
    total++; if (n !== 17) $display("FAIL to_latency got %0d exp 17", n); else pass++;
    total++; if ({res_valid, res_timeout, res_digit} !== {2'b11, e.d} || res_score !== e.s) $display("FAIL to_result got %b %0d exp 11 15 0", {res_valid, res_timeout, res_digit}, res_score); else pass++;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
`else
    repeat (1000) @(negedge clk);
    total++; if ({busy, res_valid, req_ready, res_timeout} !== 4'b1000) $display("FAIL to_waiting got %b exp 1000", {busy, res_valid, req_ready, res_timeout}); else pass++;
    rst = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, -9};
    done_dly = 5;
    n_rst = 0;
    n_start = 0;
    sb.push_back(model());
    sb.push_back(model());
    req_valid = 1;
    wait_res(n);
    e = sb.pop_front();
    total++; if (res_valid !== 1'b1 || res_digit !== e.d || res_score !== e.s) $display("FAIL b2b_first got %0d/%0d exp %0d/%0d", res_digit, res_score, e.d, e.s); else pass++;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    total++; if (req_ready !== 1'b1) $display("FAIL b2b_idle got %b exp 1", req_ready); else pass++;
    @(negedge clk);
    req_valid = 0;
    total++; if (eng_reset !== 1'b1) $display("FAIL b2b_accept got %b exp 1", eng_reset); else pass++;
    wait_res(n);
    e = sb.pop_front();
    total++; if (res_valid !== 1'b1 || res_digit !== e.d || res_score !== e.s) $display("FAIL b2b_second got %0d/%0d exp %0d/%0d", res_digit, res_score, e.d, e.s); else pass++;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    @(negedge clk);
    total++; if (n_rst !== 2 || n_start !== 2) $display("FAIL b2b_pulses got %0d/%0d exp 2/2", n_rst, n_start); else pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tie();
    test_backpressure();
    test_midreset();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/infer_seq_fix12.md
INFER_SEQ_FIX12 -- requirements
Module: infer_seq_fix12

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: width of the engine score word.
REQ-002 SHALL have parameter NUM_CLASSES, default 10: number of engine outputs scanned (max 16).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit in WAIT (used only under REQ-030).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  requester asks for one inference.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port eng_reset  output  1  one-cycle clear pulse to the engine.
REQ-009 SHALL have port eng_start  output  1  one-cycle start pulse to the engine.
REQ-010 SHALL have port eng_done  input  1  engine finished (level).
REQ-011 SHALL have port eng_out_idx  output  4  unsigned class index driven to the engine output mux.
REQ-012 SHALL have port eng_out  input  DATA_WIDTH  signed score for eng_out_idx, combinational same cycle.
REQ-013 SHALL have port res_valid  output  1  result available.
REQ-014 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port res_digit  output  4  index of the maximum score.
REQ-016 SHALL have port res_score  output  DATA_WIDTH  signed maximum score.
REQ-017 SHALL have port res_timeout  output  1  result aborted by watchdog.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> CLEAR -> START -> WAIT -> SCAN -> RESP -> IDLE.
REQ-020 SHALL drive req_ready=1 only in IDLE; handshake on req_valid && req_ready moves IDLE->CLEAR; req_valid in any other state is ignored, not queued.
REQ-021 SHALL assert eng_reset exactly during the single CLEAR cycle, then eng_start exactly during the single START cycle; both otherwise 0.
REQ-022 SHALL sample eng_done only in WAIT (entered the cycle after START); eng_done=1 in WAIT moves to SCAN with idx=0.
REQ-023 SHALL in SCAN drive eng_out_idx=idx, step idx 0..NUM_CLASSES-1 one per cycle (NUM_CLASSES cycles), then enter RESP; eng_out_idx SHALL be 0 outside SCAN.
REQ-024 SHALL at idx=0 load best_score=eng_out, best_idx=0; for idx>0 update only if eng_out > best_score (signed, strict), so ties keep the lowest index.
REQ-025 SHALL in RESP hold res_valid=1 with res_digit/res_score stable until res_ready=1, then go to IDLE the next cycle; res_valid=0 elsewhere.
REQ-026 SHALL give latency: handshake in cycle T, eng_reset in T+1, eng_start in T+2, eng_done seen in cycle D>=T+3, SCAN D+1..D+NUM_CLASSES, res_valid from D+NUM_CLASSES+1.
REQ-027 SHALL keep res_digit/res_score at the last result value outside RESP; res_timeout=0 unless REQ-030 applies.

Reset
REQ-028 SHALL on rst=0, immediately and regardless of state, force IDLE, idx=0, and outputs eng_reset=0, eng_start=0, eng_out_idx=0, res_valid=0, res_digit=0, res_score=0, res_timeout=0, busy=0; req_ready=1 once rst=1.
REQ-029 SHALL not issue eng_reset as a side effect of rst; an aborted engine run is cleared by the CLEAR pulse of the next request.

Configuration
REQ-030 SHALL, with macro INFER_SEQ_TIMEOUT_EN defined, count WAIT cycles from 0; on reaching TIMEOUT_CYCLES without eng_done, go directly to RESP with res_timeout=1, res_digit=4'hF, res_score=0; the counter clears on leaving WAIT.
REQ-031 SHALL, without INFER_SEQ_TIMEOUT_EN, omit the counter, wait indefinitely in WAIT, and tie res_timeout to 0.

Verification
REQ-032 SHALL cover nominal: scores {-5,3,120,7,0,-2048,119,1,2,4}, eng_done 20 cycles after START -> res_digit=2, res_score=120, res_valid exactly D+11.
REQ-033 SHALL cover tie: scores 500 at idx 4 and 7, rest -100 -> res_digit=4; all 10 scores -2048 -> res_digit=0, res_score=-2048.
REQ-034 SHALL cover backpressure: res_ready low 8 cycles -> res_valid and result stable 8 cycles, req_valid pulses meanwhile ignored, req_ready=1 only after release.
REQ-035 SHALL cover mid-run reset: rst=0 during SCAN idx=5 -> all outputs at reset values same cycle; next request produces fresh CLEAR/START pulses and correct result.
REQ-036 SHALL cover timeout (macro on, TIMEOUT_CYCLES=16): eng_done never asserted -> RESP after 16 WAIT cycles, res_timeout=1, res_digit=15, res_score=0; macro off -> still in WAIT after 1000 cycles.
REQ-037 SHALL cover back-to-back: two requests, req_valid held high -> second accepted one cycle after first res_ready handshake, exactly one eng_reset and one eng_start per request.
